// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks framing/CRC7,
// hands index/argument to the card model, and returns an R1-format response.
//
// state    | meaning
// IDLE     | line idle, waiting for a start bit
// RX       | shifting in frame bits 46..0
// CHECK    | one-cycle gap after the frame verdict pulse
// WAIT_RSP | waiting for the card model to offer a response
// NCR_WAIT | line held high before the response start bit
// TX       | driving the 48-bit response
module sd_cmd_responder #(
    parameter int NCR         = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sd_cmd,
    output logic        o_sd_cmd,
    output logic        o_sd_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    output logic        rsp_ready,
    input  logic        rsp_valid,
    input  logic        rsp_none,
    input  logic [31:0] rsp_status,
    output logic        crc_err,
    output logic        frame_err,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_CHECK, S_WAIT_RSP, S_NCR_WAIT, S_TX
    } state_t;

    localparam logic [5:0] NCR_LAST = 6'(NCR - 1);
    localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [7:0]  timer;
    logic [45:0] rx_sh;
    logic [39:0] tx_sh;
    logic [6:0]  crc;
    logic        frame_bad, crc_bad, timer_done;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Verdict is formed while the end bit is on the line, so the pulse lands in CHECK.
    assign frame_bad  = !rx_sh[45] || !i_sd_cmd;
    assign crc_bad    = rx_sh[6:0] != crc;
    assign timer_done = timer == TMO_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        rsp_ready   = 1'b0;
        o_sd_cmd    = 1'b1;
        o_sd_cmd_oe = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (!i_sd_cmd) state_next = S_RX;
            end
            S_RX:    if (cnt == 6'd0) state_next = S_CHECK;
            S_CHECK: state_next = cmd_valid ? S_WAIT_RSP : S_IDLE;
            S_WAIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid)       state_next = rsp_none ? S_IDLE : S_NCR_WAIT;
                else if (timer_done) state_next = S_IDLE;
            end
            S_NCR_WAIT: if (cnt == 6'd0) state_next = S_TX;
            S_TX: begin
                o_sd_cmd_oe = 1'b1;
                o_sd_cmd    = (cnt >= 6'd8) ? tx_sh[39] : ((cnt != 6'd0) ? crc[6] : 1'b1);
                if (cnt == 6'd0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= 6'd0;
            timer       <= 8'd0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            crc         <= 7'd0;
            cmd_idx     <= 6'd0;
            cmd_arg     <= 32'd0;
            cmd_valid   <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                S_IDLE: if (!i_sd_cmd) begin
                    cnt <= 6'd46;
                    crc <= crc7_step(7'd0, i_sd_cmd);
                end
                S_RX: begin
                    rx_sh <= {rx_sh[44:0], i_sd_cmd};
                    if (cnt >= 6'd8) crc <= crc7_step(crc, i_sd_cmd);
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                    else if (frame_bad) frame_err <= 1'b1;
                    else if (crc_bad)   crc_err   <= 1'b1;
                    else begin
                        cmd_valid <= 1'b1;
                        cmd_idx   <= rx_sh[44:39];
                        cmd_arg   <= rx_sh[38:7];
                    end
                end
                S_CHECK: timer <= 8'd0;
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        tx_sh <= {2'b00, cmd_idx, rsp_status};
                        cnt   <= NCR_LAST;
                        crc   <= 7'd0;
                    end else if (timer_done) begin
                        rsp_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_NCR_WAIT: cnt <= (cnt == 6'd0) ? 6'd47 : cnt - 6'd1;
                S_TX: begin
                    // CRC accumulates on the 40 payload bits, then drains MSB first.
                    if (cnt >= 6'd8) begin
                        crc   <= crc7_step(crc, tx_sh[39]);
                        tx_sh <= {tx_sh[38:0], 1'b0};
                    end else begin
                        crc <= {crc[5:0], 1'b0};
                    end
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
